multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control FSM for the 11-opcode custom ISA (lw sw add jr jal nor nori not bleu rolv rorv).
//  Sits beside the shared-ALU / single-memory datapath; sequences fetch, decode, execute, memory, writeback.
//  Adds a memory ready handshake, a wait-state watchdog and a retire pulse.
// PARAMETERS
//  ALUCTL_W     5        ALU control width; alu_control = instr[31:31-ALUCTL_W+1].
//  ALU_ADD      5'b10000 ALU code driven for address/PC arithmetic.
//  MEM_TIMEOUT  15       max mem wait cycles before abort; 0 = watchdog disabled.
// PORTS
//  clk          in   1  clock, rising edge.
//  reset        in   1  synchronous, active-high.
//  instr        in   32 instruction register contents (valid from DECODE on).
//  mem_ready    in   1  memory completes the current request this cycle.
//  branch_cond  in   1  datapath bleu compare result (rs <= rt, unsigned).
//  mem_req      out  1  memory request; held until mem_ready.
//  mem_write    out  1  request is a store.
//  iord         out  1  0 = address from PC, 1 = from ALUOut.
//  ir_write     out  1  latch fetched word into IR.
//  pc_write     out  1  update PC.
//  pc_src       out  2  00 ALU(PC+4), 01 branch target, 10 rs (jr), 11 jump target (jal).
//  alu_src_a    out  1  0 = PC, 1 = rs.
//  alu_src_b    out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
//  alu_control  out  ALUCTL_W ALU operation.
//  reg_write, reg_dst, mem_to_reg, link  out 1 each: regfile write enable, dest rd(1)/rt(0), data from mem, write PC+4 to $31.
//  retire       out  1  one-cycle pulse when an instruction completes.
//  mem_timeout  out  1  sticky; set on watchdog expiry, cleared only by reset.
//  illegal      out  1  sticky; illegal opcode seen (trap build only).
// BEHAVIOUR
//  Clock clk, reset synchronous active-high. Reset: state FETCH, wait counter 0, mem_timeout/illegal 0.
//  Outputs decoded from state register (Moore) except where gated by mem_ready/branch_cond; all outputs 0 unless listed below.
//  Opcode = instr[31:26]: lw 100011, sw 101011, add 100000, jr 001000, jal 000011, nor 100110,
//   nori 001110, not 000100, bleu 010000, rolv 000000, rorv 000010.
//  FETCH: mem_req, alu_src_b=01, alu_control=ALU_ADD; ir_write=pc_write=mem_ready; mem_ready -> DECODE else stay.
//  DECODE: alu_src_b=11, alu_control=ALU_ADD (branch target). Next: lw/sw->MEMADDR; add/nor/not/rolv/rorv->EXEC_R;
//   nori->EXEC_I; bleu->BRANCH; jr->JR; jal->JAL; other->ILLEGAL handling (see CONFIGURATION).
//  MEMADDR: alu_src_a=1, alu_src_b=10, alu_control=ALU_ADD; lw->MEMRD, sw->MEMWR.
//  MEMRD: mem_req, iord; mem_ready -> MEMWB. MEMWB: reg_write, mem_to_reg, reg_dst=0, retire -> FETCH.
//  MEMWR: mem_req, mem_write, iord; mem_ready -> retire, FETCH.
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_control=instr opcode bits -> RWB (reg_write, reg_dst=1, retire -> FETCH).
//  EXEC_I: alu_src_a=1, alu_src_b=10, alu_control=instr bits -> IWB (reg_write, reg_dst=0, retire -> FETCH).
//  BRANCH: alu_src_a=1, alu_control=instr bits, pc_src=01, pc_write=branch_cond, retire -> FETCH.
//  JR: pc_src=10, pc_write, retire -> FETCH. JAL: reg_write, link, pc_src=11, pc_write, retire -> FETCH.
//  Latency (cycles incl. fetch, zero wait): lw 5, sw 4, R/I-type 4, bleu/jr/jal 3.
//  Wait counter: increments each cycle in FETCH/MEMRD/MEMWR with mem_req && !mem_ready; clears on state exit.
//  Watchdog (MEM_TIMEOUT>0): counter == MEM_TIMEOUT and !mem_ready -> mem_timeout=1, drop mem_req, go FETCH,
//   no retire, no PC/IR/regfile/memory write. mem_ready on the expiry cycle wins (normal completion).
//  Reset asserted mid-instruction: aborts at next edge, no retire, no writes in the reset cycle's successor.
//  retire never asserts two consecutive cycles.
// CONFIGURATION
//  MULTICYCLE_CTRL_TRAP_EN defined: illegal opcode in DECODE -> TRAP state: illegal=1 (sticky), pc_write=0,
//   FSM stays in TRAP (mem_req=0) until reset.
//  Not defined: illegal opcode treated as NOP: retire in DECODE, -> FETCH; illegal tied 0; no TRAP state.
// TESTING
//  reset, then lw (0x8C..), mem_ready 1 each req -> states F,D,MA,MR,WB; retire cycle 5; mem_to_reg=1 in WB.
//  sw with mem_ready low 3 cycles in MEMWR -> mem_req/mem_write held 4 cycles, retire with ready, no reg_write.
//  bleu branch_cond=1 then 0 -> pc_write=1,pc_src=01 first; pc_write=0 second; both retire cycle 3.
//  jal -> JAL cycle: reg_write=link=pc_write=1, pc_src=11; add -> alu_control=10000, reg_dst=1 in RWB.
//  MEM_TIMEOUT=3, mem_ready held 0 in FETCH -> mem_timeout=1 after 4th wait cycle, FSM FETCH, no ir_write.
//  opcode 111111: TRAP_EN -> illegal=1, stuck until reset; no TRAP_EN -> retire in DECODE, next fetch.

Source files
------------

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
//   Bundles the controller <-> datapath/memory signals of the multi-cycle
//   control FSM.
//   master : the controller (consumes instr/mem_ready/branch_cond, drives
//            every control strobe and status flag).
//   slave  : the datapath + memory side (the mirror image).
//   Signals:
//     instr        IR contents (valid from DECODE on)
//     mem_ready    memory completes the current request this cycle
//     branch_cond  bleu compare result (rs <= rt, unsigned)
//     mem_req, mem_write, iord, ir_write, pc_write, pc_src[1:0],
//     alu_src_a, alu_src_b[1:0], alu_control[ALUCTL_W-1:0],
//     reg_write, reg_dst, mem_to_reg, link, retire, mem_timeout, illegal
// ----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int unsigned ALUCTL_W = 5
);
  logic [31:0]         instr;
  logic                mem_ready;
  logic                branch_cond;
  logic                mem_req;
  logic                mem_write;
  logic                iord;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUCTL_W-1:0] alu_control;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                link;
  logic                retire;
  logic                mem_timeout;
  logic                illegal;

  modport master (
    input  instr, mem_ready, branch_cond,
    output mem_req, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
           mem_to_reg, link, retire, mem_timeout, illegal
  );

  modport slave (
    output instr, mem_ready, branch_cond,
    input  mem_req, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
           mem_to_reg, link, retire, mem_timeout, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle control FSM for the 11-opcode ISA
//   (lw sw add jr jal nor nori not bleu rolv rorv). Sequences fetch, decode,
//   execute, memory and writeback for a shared-ALU / single-memory datapath,
//   with a memory ready handshake, a wait-state watchdog and a retire pulse.
//
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  synchronous, active-high
//     bus    multicycle_control_if.master (instr/mem_ready/branch_cond in,
//            all control strobes and status flags out)
//
//   Parameters:
//     ALUCTL_W     ALU control width; alu_control = instr[31 -: ALUCTL_W]
//     ALU_ADD      ALU code used for PC / address arithmetic
//     MEM_TIMEOUT  max memory wait cycles before abort; 0 disables watchdog
//
//   Build option:
//     MULTICYCLE_CTRL_TRAP_EN  illegal opcode parks the FSM in TRAP with a
//                              sticky illegal flag; when undefined an illegal
//                              opcode retires as a NOP from DECODE.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FETCH     | read mem[PC], PC <= PC+4 and IR latch on mem_ready
//   DECODE    | compute branch target, dispatch on opcode
//   MEMADDR   | ALUOut <= rs + sign-ext imm
//   MEMRD     | load read, waits on mem_ready
//   MEMWB     | load data -> rt, retire
//   MEMWR     | store write, waits on mem_ready, retire on completion
//   EXEC_R    | R-type ALU op rs,rt
//   RWB       | ALUOut -> rd, retire
//   EXEC_I    | I-type ALU op rs,imm
//   IWB       | ALUOut -> rt, retire
//   BRANCH    | bleu: PC <= target if branch_cond, retire
//   JR        | PC <= rs, retire
//   JAL       | $31 <= PC+4, PC <= jump target, retire
//   TRAP      | illegal opcode, parked until reset (trap build only)
// ----------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned         ALUCTL_W    = 5,
  parameter logic [ALUCTL_W-1:0] ALU_ADD     = 5'b10000,
  parameter int unsigned         MEM_TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;

  // Counter only needs to reach MEM_TIMEOUT; it saturates when the watchdog is off.
  localparam int unsigned        CNT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADDR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_RWB,
    S_EXEC_I,
    S_IWB,
    S_BRANCH,
    S_JR,
    S_JAL
`ifdef MULTICYCLE_CTRL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic [5:0]          opcode;
  logic [ALUCTL_W-1:0] alu_instr;
  logic                wait_st;
  logic                expire;

  logic                mem_req, mem_write, iord, ir_write, pc_write;
  logic [1:0]          pc_src, alu_src_b;
  logic                alu_src_a;
  logic [ALUCTL_W-1:0] alu_control;
  logic                reg_write, reg_dst, mem_to_reg, link, retire;

  logic                unused_instr_bits;

  assign opcode            = bus.instr[31:26];
  assign alu_instr         = bus.instr[31 -: ALUCTL_W];
  assign unused_instr_bits = ^bus.instr[25:0];

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = '0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    link        = 1'b0;
    retire      = 1'b0;
    wait_st     = 1'b0;
    expire      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        wait_st     = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:                            state_d = S_MEMADDR;
          OP_ADD, OP_NOR, OP_NOT, OP_ROLV, OP_RORV: state_d = S_EXEC_R;
          OP_NORI:                                 state_d = S_EXEC_I;
          OP_BLEU:                                 state_d = S_BRANCH;
          OP_JR:                                   state_d = S_JR;
          OP_JAL:                                  state_d = S_JAL;
          default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            state_d = S_TRAP;
`else
            retire  = 1'b1;
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        wait_st = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        wait_st   = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = alu_instr;
        state_d     = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = alu_instr;
        state_d     = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = alu_instr;
        pc_src      = 2'b01;
        pc_write    = bus.branch_cond;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JR: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1;
        link      = 1'b1;
        pc_src    = 2'b11;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase

    // Watchdog abort: a late mem_ready on the limit cycle still completes normally.
    if ((MEM_TIMEOUT != 0) && wait_st && !bus.mem_ready && (wait_cnt_q == CNT_LIMIT)) begin
      expire    = 1'b1;
      mem_req   = 1'b0;
      mem_write = 1'b0;
      state_d   = S_FETCH;
    end

    wait_cnt_d = wait_cnt_q;
    if (expire || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (wait_st && !bus.mem_ready && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    mem_timeout_d = mem_timeout_q | expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.mem_req     = mem_req;
  assign bus.mem_write   = mem_write;
  assign bus.iord        = iord;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_control = alu_control;
  assign bus.reg_write   = reg_write;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.link        = link;
  assign bus.retire      = retire;
  assign bus.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Drives a directed prefix plus a random instruction stream into
//   multicycle_control (MEM_TIMEOUT = 3). A reactive memory driver answers
//   mem_req after a planned number of wait cycles; per-instruction expected
//   outcomes (event kind, cycle count, strobe counts, ALU code, PC source...)
//   are computed from the ISA timing rules and queued up front. A monitor
//   accumulates what the DUT does between events (retire or watchdog abort)
//   and compares against the queue head.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int TMO = 3;

  typedef struct {
    logic [31:0] instr;
    logic        bc;
    int          fw;
    int          dw;
  } item_t;

  typedef struct {
    int          kind;     // 0 retire, 1 watchdog abort
    int          cycles;
    int          regw;
    int          pcw;
    int          irw;
    int          memreq;
    int          memwr;
    logic [4:0]  alu;
    logic [1:0]  pcsrc;
    logic        m2r;
    logic        link;
    logic        regdst;
    logic        sticky;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  bit   go = 1'b0;

  int checks = 0;
  int errors = 0;

  item_t plan[$];
  exp_t  exp_q[$];

  multicycle_control_if #(.ALUCTL_W(5)) bus ();

  multicycle_control #(
    .ALUCTL_W   (5),
    .ALU_ADD    (5'b10000),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // 0 lw, 1 sw, 2 R-type, 3 nori, 4 bleu, 5 jr, 6 jal, 7 illegal
  function automatic int cls(logic [5:0] op);
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b100000, 6'b100110, 6'b000100, 6'b000000, 6'b000010: return 2;
      6'b001110: return 3;
      6'b010000: return 4;
      6'b001000: return 5;
      6'b000011: return 6;
      default:   return 7;
    endcase
  endfunction

  function automatic exp_t model(item_t it, logic sticky);
    exp_t       e;
    logic [5:0] op;
    int         k;
    e = '{default: 0};
    e.sticky = sticky;
    if (it.fw > TMO) begin
      e.kind   = 1;
      e.cycles = TMO + 1;
      e.memreq = TMO;
      return e;
    end
    op       = it.instr[31:26];
    k        = cls(op);
    e.irw    = 1;
    e.pcw    = 1;
    e.memreq = it.fw + 1;
    e.cycles = it.fw + 2;
    case (k)
      0, 1: begin
        e.alu    = 5'b10000;
        e.cycles += 1;
        if (it.dw > TMO) begin
          e.kind   = 1;
          e.cycles += TMO + 1;
          e.memreq += TMO;
          if (k == 1) e.memwr = TMO;
        end else begin
          e.cycles += it.dw + 1;
          e.memreq += it.dw + 1;
          if (k == 1) e.memwr = it.dw + 1;
          else begin
            e.cycles += 1;
            e.regw    = 1;
            e.m2r     = 1'b1;
          end
        end
      end
      2: begin e.cycles += 2; e.regw = 1; e.regdst = 1'b1; e.alu = op[5:1]; end
      3: begin e.cycles += 2; e.regw = 1; e.alu = op[5:1]; end
      4: begin
        e.cycles += 1;
        e.alu     = op[5:1];
        if (it.bc) begin e.pcw = 2; e.pcsrc = 2'b01; end
      end
      5: begin e.cycles += 1; e.pcw = 2; e.pcsrc = 2'b10; end
      6: begin e.cycles += 1; e.pcw = 2; e.pcsrc = 2'b11; e.regw = 1; e.link = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic item_t mk(logic [5:0] op, logic bc, int fw, int dw);
    item_t it;
    it.instr = {op, 26'($urandom)};
    it.bc    = bc;
    it.fw    = fw;
    it.dw    = dw;
    return it;
  endfunction

  // Reactive memory: ready is tentatively raised so mem_req is read without the
  // watchdog's combinational drop, then the real ready value is applied.
  initial begin : driver
    int    idx = 0;
    int    age = 0;
    int    w;
    int    cur_dw = 0;
    logic  req, io;
    logic  load_pend = 1'b0;
    logic [31:0] ld_instr = '0;
    logic  ld_bc = 1'b0;
    wait (go);
    forever begin
      if (load_pend) begin
        bus.instr       = ld_instr;
        bus.branch_cond = ld_bc;
        load_pend       = 1'b0;
      end
      bus.mem_ready = 1'b1;
      #1;
      req = bus.mem_req;
      io  = bus.iord;
      if (!req) begin
        bus.mem_ready = 1'b0;
        age = 0;
      end else if (!io && idx >= plan.size()) begin
        bus.mem_ready = 1'b0;
      end else begin
        w = io ? cur_dw : plan[idx].fw;
        if (age < w) begin
          bus.mem_ready = 1'b0;
          age++;
          if (age == TMO + 1) begin
            age = 0;
            if (!io) idx++;
          end
        end else begin
          bus.mem_ready = 1'b1;
          age = 0;
          if (!io) begin
            ld_instr  = plan[idx].instr;
            ld_bc     = plan[idx].bc;
            cur_dw    = plan[idx].dw;
            load_pend = 1'b1;
            idx++;
          end
        end
      end
      @(posedge clk);
      #1;
    end
  end

  initial begin : monitor
    int   cyc = 0, n_req = 0, n_wr = 0, n_ir = 0, n_pc = 0, n_rw = 0, ev = 0;
    logic [1:0] s_pcsrc = 2'b00;
    logic [4:0] s_alu = '0;
    logic s_m2r = 1'b0, s_dst = 1'b0, s_link = 1'b0;
    logic prev_req = 1'b0, prev_rdy = 1'b0, prev_ret = 1'b0;
    logic tmo_ev;
    exp_t e;
    wait (go);
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) n_req++;
      if (bus.mem_req && bus.mem_write) n_wr++;
      if (bus.ir_write) n_ir++;
      if (bus.pc_write) begin n_pc++; s_pcsrc = bus.pc_src; end
      if (bus.reg_write) begin n_rw++; s_m2r = bus.mem_to_reg; s_dst = bus.reg_dst; end
      if (bus.link) s_link = 1'b1;
      if (bus.alu_src_a) s_alu = bus.alu_control;
      tmo_ev = !bus.mem_req && prev_req && !prev_rdy && !bus.retire;
      if (bus.retire) chk("retire_back_to_back", int'(prev_ret), 0);
      if (bus.retire || tmo_ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual=%s required=none (t=%0t)",
                   bus.retire ? "retire" : "abort", $time);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("ev%0d_kind", ev),     tmo_ev ? 1 : 0, e.kind);
          chk($sformatf("ev%0d_cycles", ev),   cyc,    e.cycles);
          chk($sformatf("ev%0d_reg_write", ev), n_rw,  e.regw);
          chk($sformatf("ev%0d_pc_write", ev), n_pc,   e.pcw);
          chk($sformatf("ev%0d_ir_write", ev), n_ir,   e.irw);
          chk($sformatf("ev%0d_mem_req", ev),  n_req,  e.memreq);
          chk($sformatf("ev%0d_mem_write", ev), n_wr,  e.memwr);
          chk($sformatf("ev%0d_alu_control", ev), int'(s_alu), int'(e.alu));
          chk($sformatf("ev%0d_pc_src", ev),   int'(s_pcsrc), int'(e.pcsrc));
          chk($sformatf("ev%0d_mem_to_reg", ev), int'(s_m2r), int'(e.m2r));
          chk($sformatf("ev%0d_link", ev),     int'(s_link), int'(e.link));
          chk($sformatf("ev%0d_reg_dst", ev),  int'(s_dst), int'(e.regdst));
          chk($sformatf("ev%0d_mem_timeout", ev), int'(bus.mem_timeout), int'(e.sticky));
          chk($sformatf("ev%0d_illegal", ev),  int'(bus.illegal), 0);
        end
        ev++;
        cyc = 0; n_req = 0; n_wr = 0; n_ir = 0; n_pc = 0; n_rw = 0;
        s_pcsrc = 2'b00; s_alu = '0; s_m2r = 1'b0; s_dst = 1'b0; s_link = 1'b0;
      end
      prev_req = bus.mem_req;
      prev_rdy = bus.mem_ready;
      prev_ret = bus.retire;
    end
  end

  initial begin : main
    logic [5:0] ops [11];
    logic       sticky;
    exp_t       e;
    int         r;
    int         n;

    ops = '{6'b100011, 6'b101011, 6'b100000, 6'b001000, 6'b000011, 6'b100110,
            6'b001110, 6'b000100, 6'b010000, 6'b000000, 6'b000010};

    reset           = 1'b1;
    bus.instr       = '0;
    bus.mem_ready   = 1'b0;
    bus.branch_cond = 1'b0;

    plan.push_back(mk(6'b100011, 1'b0, 0, 0));   // lw, no waits
    plan.push_back(mk(6'b101011, 1'b0, 0, 3));   // sw, 3 waits (limit cycle wins)
    plan.push_back(mk(6'b010000, 1'b1, 0, 0));   // bleu taken
    plan.push_back(mk(6'b010000, 1'b0, 0, 0));   // bleu not taken
    plan.push_back(mk(6'b000011, 1'b0, 0, 0));   // jal
    plan.push_back(mk(6'b100000, 1'b0, 0, 0));   // add
    plan.push_back(mk(6'b100000, 1'b0, 4, 0));   // fetch watchdog abort
`ifndef MULTICYCLE_CTRL_TRAP_EN
    plan.push_back(mk(6'b111111, 1'b0, 0, 0));   // illegal -> NOP
`endif
    plan.push_back(mk(6'b101011, 1'b0, 1, 4));   // sw data watchdog abort
    plan.push_back(mk(6'b100011, 1'b0, 2, 3));   // lw, limit-cycle ready
    plan.push_back(mk(6'b001000, 1'b0, 3, 0));   // jr
    plan.push_back(mk(6'b001110, 1'b0, 0, 0));   // nori

    for (int i = 0; i < 60; i++) begin
      item_t it;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      r = $urandom_range(0, 10);
`else
      r = $urandom_range(0, 11);
`endif
      if (r == 11) it = mk(($urandom_range(0, 1) == 1) ? 6'b111111 : 6'b000001, 1'b0, 0, 0);
      else         it = mk(ops[r], 1'($urandom), 0, 0);
      it.fw = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
      it.dw = $urandom_range(0, 4);
      plan.push_back(it);
    end

    sticky = 1'b0;
    foreach (plan[i]) begin
      e = model(plan[i], sticky);
      exp_q.push_back(e);
      if (e.kind == 1) sticky = 1'b1;
    end

`ifdef MULTICYCLE_CTRL_TRAP_EN
    plan.push_back(mk(6'b111111, 1'b0, 0, 0));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", int'(bus.mem_req), 1);
    chk("reset_mem_timeout", int'(bus.mem_timeout), 0);
    chk("reset_illegal", int'(bus.illegal), 0);
    chk("reset_retire", int'(bus.retire), 0);
    chk("reset_ir_write", int'(bus.ir_write), 0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    go    = 1'b1;

    @(negedge clk);
    chk("fetch_mem_req", int'(bus.mem_req), 1);
    chk("fetch_iord", int'(bus.iord), 0);
    chk("fetch_alu_src_b", int'(bus.alu_src_b), 1);
    chk("fetch_alu_control", int'(bus.alu_control), 5'b10000);

    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end

`ifdef MULTICYCLE_CTRL_TRAP_EN
    n = 0;
    while (!bus.illegal && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("trap_illegal", int'(bus.illegal), 1);
    repeat (5) begin
      @(negedge clk);
      chk("trap_sticky", int'(bus.illegal), 1);
      chk("trap_no_mem_req", int'(bus.mem_req), 0);
      chk("trap_no_pc_write", int'(bus.pc_write), 0);
      chk("trap_no_retire", int'(bus.retire), 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
